// File: rtl/vce2_pkg.sv
// Shared types for the vce2 vector element sequencer: FSM states, ALU ops and
// the registered control-strobe bundle.
package vce2_pkg;

    localparam int unsigned VSEQ_VL_W   = 8;
    localparam int unsigned VSEQ_ADDR_W = 32;
    localparam int unsigned VSEQ_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_AGU,
        ST_RD_A,
        ST_RD_B,
        ST_WR,
        ST_DONE
    } vseq_state_e;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR
    } vec_alu_op_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic agu_load;
        logic get_rs1;
        logic get_rs2;
        logic get_rd;
        logic port_req;
        logic data_req;
        logic data_we;
    } vseq_ctrl_t;

    // Strobes that must be visible while the FSM sits in state s
    function automatic vseq_ctrl_t ctrl_for(vseq_state_e s);
        vseq_ctrl_t c;
        c      = '0;
        c.busy = (s != ST_IDLE);
        case (s)
            ST_LOAD: begin
                c.agu_load = 1'b1;
                c.port_req = 1'b1;
            end
            ST_WAIT_AGU: c.port_req = 1'b1;
            ST_RD_A: begin
                c.port_req = 1'b1;
                c.get_rs1  = 1'b1;
                c.data_req = 1'b1;
            end
            ST_RD_B: begin
                c.port_req = 1'b1;
                c.get_rs2  = 1'b1;
                c.data_req = 1'b1;
            end
            ST_WR: begin
                c.port_req = 1'b1;
                c.get_rd   = 1'b1;
                c.data_req = 1'b1;
                c.data_we  = 1'b1;
            end
            ST_DONE: c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vce2_vseq_if.sv
// Bundle of control, AGU, data-port and ALU signals around the vector sequencer.
interface vce2_vseq_if #(
    parameter int unsigned VlWidth = vce2_pkg::VSEQ_VL_W
) ();
    import vce2_pkg::*;

    logic                   start_i;
    logic [VlWidth-1:0]     vl_i;
    vec_alu_op_e            op_i;
    logic                   flush_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    logic                   agu_load_o;
    logic                   agu_ready_i;
    logic                   agu_get_rs1_o;
    logic                   agu_get_rs2_o;
    logic                   agu_get_rd_o;
    logic                   agu_get_rd_noincr_o;

    logic                   port_req_o;
    logic                   port_gnt_i;
    logic                   data_req_o;
    logic                   data_we_o;
    logic [VSEQ_DATA_W-1:0] data_wdata_o;
    logic                   data_rvalid_i;
    logic [VSEQ_DATA_W-1:0] data_rdata_i;

    vec_alu_op_e            alu_op_o;
    logic [VSEQ_DATA_W-1:0] alu_op_a_o;
    logic [VSEQ_DATA_W-1:0] alu_op_b_o;
    logic [VSEQ_DATA_W-1:0] alu_result_i;

    modport slave (
        input  start_i, vl_i, op_i, flush_i,
        output busy_o, done_o, err_o,
        output agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_get_rd_noincr_o,
        input  agu_ready_i,
        output port_req_o, data_req_o, data_we_o, data_wdata_o,
        input  port_gnt_i, data_rvalid_i, data_rdata_i,
        output alu_op_o, alu_op_a_o, alu_op_b_o,
        input  alu_result_i
    );

    modport master (
        output start_i, vl_i, op_i, flush_i,
        input  busy_o, done_o, err_o,
        input  agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_get_rd_noincr_o,
        output agu_ready_i,
        input  port_req_o, data_req_o, data_we_o, data_wdata_o,
        output port_gnt_i, data_rvalid_i, data_rdata_i,
        input  alu_op_o, alu_op_a_o, alu_op_b_o,
        output alu_result_i
    );

endinterface

// File: rtl/vce2_vseq.sv
// Vector element sequencer: loads the AGU, holds the data port, and streams
// vs1/vs2 reads and vd writes through the external ALU, 3 cycles per element.
module vce2_vseq
    import vce2_pkg::*;
#(
    parameter int unsigned VlWidth = VSEQ_VL_W
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    vce2_vseq_if.slave     bus
);

    vseq_state_e            state_q, state_d;
    vseq_ctrl_t             ctrl_q, ctrl_d;
    logic [VlWidth-1:0]     vl_q, vl_d;
    logic [VlWidth-1:0]     cnt_q, cnt_d;
    vec_alu_op_e            op_q, op_d;
    logic [VSEQ_DATA_W-1:0] op_a_q, op_a_d;
    logic                   err_q, err_d;
    logic                   gnt_seen_q, gnt_seen_d;
    logic                   rdy_seen_q, rdy_seen_d;
    logic                   gnt_ok, rdy_ok;

    assign gnt_ok = bus.port_gnt_i  | gnt_seen_q;
    assign rdy_ok = bus.agu_ready_i | rdy_seen_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            vl_q       <= '0;
            cnt_q      <= '0;
            op_q       <= ALU_ADD;
            op_a_q     <= '0;
            err_q      <= 1'b0;
            gnt_seen_q <= 1'b0;
            rdy_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            vl_q       <= vl_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_a_q     <= op_a_d;
            err_q      <= err_d;
            gnt_seen_q <= gnt_seen_d;
            rdy_seen_q <= rdy_seen_d;
        end
    end

    // Next state; strobes are decoded from the next state so they leave a flop
    always_comb begin
        state_d    = state_q;
        vl_d       = vl_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        op_a_d     = op_a_q;
        err_d      = err_q;
        gnt_seen_d = gnt_seen_q;
        rdy_seen_d = rdy_seen_q;

        if (bus.flush_i) begin
            state_d    = ST_IDLE;
            gnt_seen_d = 1'b0;
            rdy_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        err_d      = 1'b0;
                        cnt_d      = '0;
                        gnt_seen_d = 1'b0;
                        rdy_seen_d = 1'b0;
                        if (bus.vl_i == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                            vl_d    = bus.vl_i;
                            op_d    = bus.op_i;
                        end
                    end
                end
                ST_LOAD: begin
                    state_d    = ST_WAIT_AGU;
                    gnt_seen_d = gnt_ok;
                    rdy_seen_d = rdy_ok;
                end
                ST_WAIT_AGU: begin
                    if (gnt_ok && rdy_ok) begin
                        state_d    = ST_RD_A;
                        gnt_seen_d = 1'b0;
                        rdy_seen_d = 1'b0;
                    end else begin
                        gnt_seen_d = gnt_ok;
                        rdy_seen_d = rdy_ok;
                    end
                end
                ST_RD_A: state_d = ST_RD_B;
                ST_RD_B: begin
                    if (bus.data_rvalid_i) begin
                        op_a_d = bus.data_rdata_i;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_WR;
                end
                ST_WR: begin
                    if (!bus.data_rvalid_i) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == vl_q - VlWidth'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + VlWidth'(1);
                        state_d = ST_RD_A;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        ctrl_d = ctrl_for(state_d);
    end

    assign bus.busy_o              = ctrl_q.busy;
    assign bus.done_o              = ctrl_q.done;
    assign bus.err_o               = err_q;
    assign bus.agu_load_o          = ctrl_q.agu_load;
    assign bus.agu_get_rs1_o       = ctrl_q.get_rs1;
    assign bus.agu_get_rs2_o       = ctrl_q.get_rs2;
    assign bus.agu_get_rd_o        = ctrl_q.get_rd;
    assign bus.agu_get_rd_noincr_o = 1'b0;
    assign bus.port_req_o          = ctrl_q.port_req;
    assign bus.data_req_o          = ctrl_q.data_req;
    assign bus.data_we_o           = ctrl_q.data_we;
    assign bus.alu_op_o            = op_q;
    assign bus.alu_op_a_o          = op_a_q;

    // vs2 data and the ALU result pass straight through during the write cycle
    assign bus.alu_op_b_o   = ctrl_q.data_we ? bus.data_rdata_i : '0;
    assign bus.data_wdata_o = ctrl_q.data_we ? bus.alu_result_i : '0;

endmodule

// File: tb/tb_vce2_vseq.sv
// Directed bench for vce2_vseq with small AGU, arbiter, memory and ALU models.
module tb_vce2_vseq;
    import vce2_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    vce2_vseq_if #(.VlWidth(8)) bus ();

    vce2_vseq #(.VlWidth(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        gnt_allow = 1'b1;
    logic        suppress  = 1'b0;
    logic [2:0]  sh        = '0;
    logic [31:0] rq[$];

    int n_load = 0, n_preq = 0, n_dreq = 0, n_done = 0;
    int n_rs1 = 0, n_rs2 = 0, n_rd = 0;

    // Arbiter grants combinationally while allowed; AGU is ready 3 cycles after load
    assign bus.port_gnt_i  = bus.port_req_o & gnt_allow;
    assign bus.agu_ready_i = sh[2];

    always_comb begin
        case (bus.alu_op_o)
            ALU_ADD: bus.alu_result_i = bus.alu_op_a_o + bus.alu_op_b_o;
            ALU_SUB: bus.alu_result_i = bus.alu_op_a_o - bus.alu_op_b_o;
            ALU_AND: bus.alu_result_i = bus.alu_op_a_o & bus.alu_op_b_o;
            default: bus.alu_result_i = bus.alu_op_a_o | bus.alu_op_b_o;
        endcase
    end

    // Memory with 1-cycle read latency, returns queued words in order
    always @(posedge clk_i) begin
        bus.data_rvalid_i <= 1'b0;
        if (bus.data_req_o && !bus.data_we_o) begin
            bus.data_rvalid_i <= !suppress;
            bus.data_rdata_i  <= (rq.size() > 0) ? rq.pop_front() : 32'hdead_beef;
        end
        sh <= {sh[1:0], bus.agu_load_o};
        if (bus.agu_load_o)    n_load <= n_load + 1;
        if (bus.port_req_o)    n_preq <= n_preq + 1;
        if (bus.data_req_o)    n_dreq <= n_dreq + 1;
        if (bus.done_o)        n_done <= n_done + 1;
        if (bus.agu_get_rs1_o) n_rs1  <= n_rs1 + 1;
        if (bus.agu_get_rs2_o) n_rs2  <= n_rs2 + 1;
        if (bus.agu_get_rd_o)  n_rd   <= n_rd + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Start in cycle 0, return positioned in cycle 1
    task automatic go(input logic [7:0] vl, input vec_alu_op_e op);
        bus.start_i = 1'b1;
        bus.vl_i    = vl;
        bus.op_i    = op;
        cyc         = 0;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    int s_load, s_preq, s_dreq, s_done, s_rs1, s_rs2, s_rd;

    initial begin
        rst_ni      = 1'b0;
        bus.start_i = 1'b0;
        bus.vl_i    = '0;
        bus.op_i    = ALU_ADD;
        bus.flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_preq", 32'(bus.port_req_o), 32'd0);
        check("rst_dreq", 32'(bus.data_req_o), 32'd0);
        check("rst_load", 32'(bus.agu_load_o), 32'd0);
        check("rst_wdata", bus.data_wdata_o, 32'd0);
        rst_ni = 1'b1;
        tick();

        // vl=2 ADD, grant from cycle 1: writes 12 @7 and 3 @10, done @11
        rq = '{32'd5, 32'd7, 32'd1, 32'd2};
        go(8'd2, ALU_ADD);
        for (int c = 1; c <= 12; c++) begin
            check("v2_busy", 32'(bus.busy_o), 32'(c <= 11));
            check("v2_load", 32'(bus.agu_load_o), 32'(c == 1));
            check("v2_preq", 32'(bus.port_req_o), 32'(c >= 1 && c <= 10));
            check("v2_dreq", 32'(bus.data_req_o), 32'(c >= 5 && c <= 10));
            check("v2_rs1", 32'(bus.agu_get_rs1_o), 32'(c == 5 || c == 8));
            check("v2_rs2", 32'(bus.agu_get_rs2_o), 32'(c == 6 || c == 9));
            check("v2_we", 32'(bus.data_we_o), 32'(c == 7 || c == 10));
            check("v2_done", 32'(bus.done_o), 32'(c == 11));
            if (c == 7) begin
                check("v2_opa0", bus.alu_op_a_o, 32'd5);
                check("v2_opb0", bus.alu_op_b_o, 32'd7);
                check("v2_wd0", bus.data_wdata_o, 32'd12);
            end
            if (c == 10) check("v2_wd1", bus.data_wdata_o, 32'd3);
            tick();
        end
        check("v2_err", 32'(bus.err_o), 32'd0);

        // Asynchronous reset in cycle 8 of a vl=4 SUB op
        rq = '{32'd20, 32'd5, 32'd8, 32'd3, 32'd1, 32'd1, 32'd1, 32'd1};
        go(8'd4, ALU_SUB);
        run_to(8);
        rst_ni = 1'b0;
        #1;
        check("mr_busy", 32'(bus.busy_o), 32'd0);
        check("mr_preq", 32'(bus.port_req_o), 32'd0);
        check("mr_dreq", 32'(bus.data_req_o), 32'd0);
        check("mr_rs1", 32'(bus.agu_get_rs1_o), 32'd0);
        check("mr_aluop", 32'(bus.alu_op_o), 32'd0);
        check("mr_opa", bus.alu_op_a_o, 32'd0);
        check("mr_err", 32'(bus.err_o), 32'd0);
        tick();
        tick();
        rq.delete();
        rst_ni = 1'b1;
        tick();

        // Clean op after reset: vl=1 ADD, 6+1 written in cycle 7, done in 8
        rq = '{32'd6, 32'd1};
        go(8'd1, ALU_ADD);
        run_to(7);
        check("ar_we", 32'(bus.data_we_o), 32'd1);
        check("ar_wd", bus.data_wdata_o, 32'd7);
        tick();
        check("ar_done", 32'(bus.done_o), 32'd1);
        tick();
        check("ar_busy", 32'(bus.busy_o), 32'd0);

        // vl=0: done in cycle 1 only, no AGU or port activity
        s_load = n_load; s_preq = n_preq; s_dreq = n_dreq;
        go(8'd0, ALU_ADD);
        check("v0_done1", 32'(bus.done_o), 32'd1);
        check("v0_busy1", 32'(bus.busy_o), 32'd1);
        tick();
        check("v0_done2", 32'(bus.done_o), 32'd0);
        check("v0_busy2", 32'(bus.busy_o), 32'd0);
        tick();
        check("v0_load", 32'(n_load - s_load), 32'd0);
        check("v0_preq", 32'(n_preq - s_preq), 32'd0);
        check("v0_dreq", 32'(n_dreq - s_dreq), 32'd0);

        // Grant withheld until cycle 8: RD_A moves from 5 to 9
        s_rs1 = n_rs1; s_rs2 = n_rs2; s_rd = n_rd;
        gnt_allow = 1'b0;
        rq = '{32'd9, 32'd4, 32'd3, 32'd3};
        go(8'd2, ALU_SUB);
        for (int c = 1; c <= 16; c++) begin
            if (c == 8) gnt_allow = 1'b1;
            check("lg_preq", 32'(bus.port_req_o), 32'(c >= 1 && c <= 14));
            check("lg_rs1", 32'(bus.agu_get_rs1_o), 32'(c == 9 || c == 12));
            check("lg_we", 32'(bus.data_we_o), 32'(c == 11 || c == 14));
            check("lg_done", 32'(bus.done_o), 32'(c == 15));
            if (c == 11) check("lg_wd0", bus.data_wdata_o, 32'd5);
            if (c == 14) check("lg_wd1", bus.data_wdata_o, 32'd0);
            tick();
        end
        check("lg_nrs1", 32'(n_rs1 - s_rs1), 32'd2);
        check("lg_nrs2", 32'(n_rs2 - s_rs2), 32'd2);
        check("lg_nrd", 32'(n_rd - s_rd), 32'd2);

        // Flush in cycle 6 of vl=3: idle in 7, no more commands, no done
        rq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        go(8'd3, ALU_AND);
        run_to(6);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("fl_busy", 32'(bus.busy_o), 32'd0);
        check("fl_preq", 32'(bus.port_req_o), 32'd0);
        check("fl_dreq", 32'(bus.data_req_o), 32'd0);
        check("fl_done", 32'(bus.done_o), 32'd0);
        s_dreq = n_dreq; s_done = n_done;
        repeat (8) tick();
        check("fl_ndreq", 32'(n_dreq - s_dreq), 32'd0);
        check("fl_ndone", 32'(n_done - s_done), 32'd0);
        rq.delete();

        // Missing read data in RD_B sets a sticky error, cleared by next start
        rq = '{32'd3, 32'd12};
        go(8'd1, ALU_OR);
        run_to(5);
        suppress = 1'b1;
        tick();
        suppress = 1'b0;
        tick();
        check("er_set", 32'(bus.err_o), 32'd1);
        run_to(10);
        check("er_busy", 32'(bus.busy_o), 32'd0);
        check("er_stky", 32'(bus.err_o), 32'd1);
        rq = '{32'd6, 32'd1};
        go(8'd1, ALU_ADD);
        check("er_clr", 32'(bus.err_o), 32'd0);
        run_to(7);
        check("er_wd", bus.data_wdata_o, 32'd7);
        tick();
        check("er_done", 32'(bus.done_o), 32'd1);
        check("er_clr2", 32'(bus.err_o), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
